// File: rtl/timer_dev_pkg.sv
// timer_dev_pkg: register offsets, CTRL bit positions, MODE encodings and FSM states for timer_dev.
package timer_dev_pkg;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_RSVD   = 2'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

endpackage

// File: rtl/timer_dev.sv
// timer_dev: memory-mapped countdown timer with preset reload and maskable interrupt.
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset
//   DEV_Addr - byte address from the bridge, only [3:2] decoded
//   DEV_WD   - write data
//   WE       - write strobe (already gated by the bridge's address hit)
//   RD       - combinational read data for DEV_Addr[3:2]
//   IRQ      - interrupt request, CTRL.IM & pending
module timer_dev
    import timer_dev_pkg::*;
#(
    parameter int                 DATA_W    = 32,
    parameter logic [DATA_W-1:0]  CTRL_MASK = DATA_W'(32'h0000_000F)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       DEV_Addr,
    input  logic [DATA_W-1:0] DEV_WD,
    input  logic              WE,
    output logic [DATA_W-1:0] RD,
    output logic              IRQ
);

    state_t            r_state, w_state_n;
    logic [DATA_W-1:0] r_ctrl, w_ctrl_n;
    logic [DATA_W-1:0] r_preset, w_preset_n;
    logic [DATA_W-1:0] r_count, w_count_n;
    logic              r_pend, w_pend_n;
    logic [1:0]        w_off;
    logic              w_cfg_wr;
    logic              w_unused;

    assign w_off    = DEV_Addr[3:2];
    assign w_unused = ^{DEV_Addr[31:4], DEV_Addr[1:0]};
    assign w_cfg_wr = WE && (w_off == OFF_CTRL || w_off == OFF_PRESET);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_ctrl   <= '0;
            r_preset <= '0;
            r_count  <= '0;
            r_pend   <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_ctrl   <= w_ctrl_n;
            r_preset <= w_preset_n;
            r_count  <= w_count_n;
            r_pend   <= w_pend_n;
        end
    end

    // A CTRL/PRESET write pre-empts the FSM for that cycle: the state
    // returns to IDLE, pending clears and COUNT holds its value.
    always_comb begin
        w_state_n  = r_state;
        w_ctrl_n   = r_ctrl;
        w_preset_n = r_preset;
        w_count_n  = r_count;
        w_pend_n   = r_pend;
        if (w_cfg_wr) begin
            w_state_n = ST_IDLE;
            w_pend_n  = 1'b0;
            if (w_off == OFF_CTRL)
                w_ctrl_n = DEV_WD & CTRL_MASK;
            else
                w_preset_n = DEV_WD;
        end else begin
            case (r_state)
                ST_IDLE: w_state_n = r_ctrl[CTRL_EN] ? ST_LOAD : ST_IDLE;
                ST_LOAD: begin
                    w_count_n = r_preset;
                    w_state_n = ST_CNT;
                end
                ST_CNT: begin
                    if (!r_ctrl[CTRL_EN]) begin
                        w_state_n = ST_IDLE;
                    end else if (r_count > DATA_W'(1)) begin
                        w_count_n = r_count - DATA_W'(1);
                    end else begin
                        // Terminal count is 1 or 0, so a zero preset never wraps.
                        w_count_n = '0;
                        w_pend_n  = 1'b1;
                        w_state_n = ST_INT;
                    end
                end
                default: begin
                    w_state_n = ST_IDLE;
                    if (r_ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD)
                        w_pend_n = 1'b0;
                    else
                        w_ctrl_n[CTRL_EN] = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        RD = '0;
        case (w_off)
            OFF_CTRL:   RD = r_ctrl;
            OFF_PRESET: RD = r_preset;
            OFF_COUNT:  RD = r_count;
            default:    RD = '0;
        endcase
    end

    assign IRQ = r_ctrl[CTRL_IM] & r_pend;

endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: directed self-checking bench for timer_dev.
module tb_timer_dev;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] DEV_Addr;
    logic [31:0] DEV_WD;
    logic        WE;
    logic [31:0] RD;
    logic        IRQ;

    int n_checks = 0;
    int n_fails  = 0;

    timer_dev dut (
        .clk(clk), .rst_n(rst_n), .DEV_Addr(DEV_Addr), .DEV_WD(DEV_WD),
        .WE(WE), .RD(RD), .IRQ(IRQ)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        DEV_Addr = a;
        DEV_WD   = d;
        WE       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        WE = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
        DEV_Addr = a;
        #1;
        check(tag, RD, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        check(tag, {31'b0, IRQ}, {31'b0, exp});
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b1; WE = 1'b0; DEV_Addr = '0; DEV_WD = '0;
        #3 rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        chk_reg("rst_ctrl",   32'h0, 32'h0);
        chk_reg("rst_preset", 32'h4, 32'h0);
        chk_reg("rst_count",  32'h8, 32'h0);
        chk_irq("rst_irq", 1'b0);

        // one-shot, PRESET=3
        wr(32'h4, 32'd3);
        wr(32'h0, 32'h9);
        step(2);
        chk_reg("os_cnt3", 32'h8, 32'd3);
        step(1);
        chk_reg("os_cnt2", 32'h8, 32'd2);
        step(1);
        chk_reg("os_cnt1", 32'h8, 32'd1);
        chk_irq("os_irq_early", 1'b0);
        step(1);
        chk_reg("os_cnt0", 32'h8, 32'd0);
        chk_irq("os_irq_rise", 1'b1);
        step(2);
        chk_irq("os_irq_hold", 1'b1);
        chk_reg("os_ctrl", 32'h0, 32'h8);
        wr(32'h0, 32'h8);
        chk_irq("os_irq_clr", 1'b0);

        // auto-reload, PRESET=2: pulses at +4, +9, +14
        wr(32'h4, 32'd2);
        wr(32'h0, 32'hB);
        for (int k = 1; k <= 16; k++) begin
            step(1);
            chk_irq($sformatf("ar_irq_%0d", k), (k == 4 || k == 9 || k == 14));
        end
        chk_reg("ar_ctrl", 32'h0, 32'hB);
        wr(32'h0, 32'h0);

        // masked interrupt, PRESET=1
        wr(32'h4, 32'd1);
        wr(32'h0, 32'h1);
        for (int k = 1; k <= 6; k++) begin
            step(1);
            chk_irq($sformatf("mask_irq_%0d", k), 1'b0);
        end
        chk_reg("mask_cnt",  32'h8, 32'h0);
        chk_reg("mask_ctrl", 32'h0, 32'h0);

        // register access
        wr(32'h0, 32'hFFFF_FFFF);
        chk_reg("ctrl_mask", 32'h0, 32'hF);
        wr(32'h0, 32'h0);
        wr(32'h4, 32'd7);
        wr(32'h0, 32'h1);
        step(2);
        chk_reg("ra_cnt7", 32'h8, 32'd7);
        wr(32'h0, 32'h0);
        wr(32'h8, 32'h55);
        chk_reg("ra_cnt_ro", 32'h8, 32'd7);
        wr(32'hC, 32'h1234);
        chk_reg("ra_rsvd",   32'hC, 32'h0);
        chk_reg("ra_preset", 32'h4, 32'd7);
        chk_reg("ra_ctrl",   32'h0, 32'h0);

        // PRESET=0 behaves as 1
        wr(32'h4, 32'd0);
        wr(32'h0, 32'h9);
        step(2);
        chk_reg("p0_cnt_load", 32'h8, 32'h0);
        chk_irq("p0_irq_early", 1'b0);
        step(1);
        chk_reg("p0_cnt_nowrap", 32'h8, 32'h0);
        chk_irq("p0_irq", 1'b1);
        step(1);
        chk_reg("p0_cnt_after", 32'h8, 32'h0);
        wr(32'h0, 32'h0);

        // rewrite PRESET mid-count
        wr(32'h4, 32'd10);
        wr(32'h0, 32'h9);
        step(6);
        chk_reg("wc_cnt6", 32'h8, 32'd6);
        wr(32'h4, 32'd4);
        step(2);
        chk_reg("wc_reload4", 32'h8, 32'd4);
        step(3);
        chk_irq("wc_irq_early", 1'b0);
        step(1);
        chk_irq("wc_irq", 1'b1);
        wr(32'h0, 32'h0);

        // asynchronous reset mid-count
        wr(32'h4, 32'd8);
        wr(32'h0, 32'h9);
        step(5);
        chk_reg("rm_cnt5", 32'h8, 32'd5);
        rst_n = 1'b0;
        chk_reg("rm_count",  32'h8, 32'h0);
        chk_reg("rm_ctrl",   32'h0, 32'h0);
        chk_reg("rm_preset", 32'h4, 32'h0);
        chk_irq("rm_irq", 1'b0);
        step(1);
        rst_n = 1'b1;
        step(3);
        chk_reg("rm_idle_cnt", 32'h8, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/timer_dev.md
Name: timer_dev

Overview:
- Memory-mapped countdown timer: the device-side responder behind the system bridge's timer0/timer1 slots.
- Receives the bridge's shared address and write data plus a per-device 1-bit write enable, and returns read data combinationally.
- Counts down from a preset value and raises an interrupt request toward the interrupt/CP0 logic.
- Two instances (timer0, timer1) live at the bridge's TIMER0/TIMER1 address windows.

Parameters:
- DATA_W, 32, register and counter width.
- CTRL_MASK, 32'h0000_000F, writable bits of CTRL; all other CTRL bits read 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- DEV_Addr  in  32  byte address from the bridge; only [3:2] decoded (the bridge has already done range selection).
- DEV_WD  in  DATA_W  write data from the bridge.
- WE  in  1  write strobe; the bridge drives it as timerN_WE (OR of PrWE, gated by hit).
- RD  out  DATA_W  read data, combinational from DEV_Addr[3:2].
- IRQ  out  1  interrupt request = CTRL.IM & irq_pending.

Behaviour:
- Register map (offset = DEV_Addr[3:2]):
  - 0 CTRL: bit0 EN, bits[2:1] MODE, bit3 IM.
  - 1 PRESET: read/write.
  - 2 COUNT: read-only; writes ignored.
  - 3: reads 0; writes ignored.
- Reset (rst_n low, async): CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_pending=0, IRQ=0.
- Reads: RD reflects current register values with zero latency. No read side effects.
- Writes take effect at the clock edge when WE=1.
  - A write to CTRL or PRESET forces state to IDLE and clears irq_pending in that same cycle.
  - The register write wins over any FSM update to CTRL.EN in that cycle.
- FSM, one transition per clk:
  - IDLE: if EN -> LOAD; else stay.
  - LOAD: COUNT <= PRESET; -> CNT.
  - CNT:
    - If !EN -> IDLE; COUNT holds.
    - Else if COUNT > 1: COUNT <= COUNT-1.
    - Else (COUNT is 1 or 0): COUNT <= 0, irq_pending <= 1, -> INT.
  - INT:
    - MODE=00 (one-shot): EN <= 0; -> IDLE; irq_pending stays set until the next CTRL/PRESET write.
    - MODE=01 (auto-reload): irq_pending <= 0; -> IDLE. IRQ is a 1-cycle pulse; the counter then reloads because EN is still 1.
    - MODE=1x: treated as 00.
- Period: with PRESET=N≥1 and EN set at edge t, IRQ rises at edge t+N+2. In mode 01, successive IRQ pulses are N+3 cycles apart.
- PRESET=0: behaves as PRESET=1 (COUNT underflow never occurs; no wrap to 0xFFFFFFFF).
- IM=0: irq_pending still updates; IRQ stays 0. Setting IM while irq_pending=1 requires a CTRL write, which clears pending, so no stale IRQ escapes.
- Reset mid-count: immediate return to all-zero state regardless of FSM state.
- Writes to CTRL bits outside CTRL_MASK are discarded.

Decomposition:
- Shared macros header (alongside the existing address macros): register offsets, CTRL bit positions, MODE encodings, and FSM state encodings IDLE/LOAD/CNT/INT.
- Single module; no sub-module needed.

Test Plan:
- Reset: drive rst_n=0 mid-CNT with COUNT=5 -> COUNT=0, CTRL=0, IRQ=0 immediately, before the next edge.
- One-shot:
  - Write PRESET=3, then CTRL=0x9 (IM=1, MODE=00, EN=1) -> COUNT reads 3,2,1,0.
  - IRQ rises 5 cycles after the CTRL write and stays high.
  - CTRL reads 0x8.
  - Writing CTRL=0x8 drops IRQ next cycle.
- Auto-reload: PRESET=2, CTRL=0xB -> IRQ single-cycle pulses every 5 cycles, at least 3 pulses; EN remains 1.
- Masked: PRESET=1, CTRL=0x1 -> IRQ never asserts; the counter still reaches 0 and EN clears.
- Register access:
  - Write 0xFFFF_FFFF to CTRL -> reads 0xF.
  - Write to offset 8 -> COUNT unchanged.
  - Offset 0xC reads 0.
  - PRESET=0, EN=1 -> COUNT goes to 0 with no wrap, and IRQ asserts.
- Write during count: PRESET=10 counting at COUNT=6, then write PRESET=4 -> FSM goes to IDLE, reloads 4 two cycles later, and IRQ follows at 4 plus the original latency.
